// File: rtl/pulse_capture.sv
// pulse_capture: measures high time and rising-to-rising period of an
// external pulse train in prescaled ticks, with valid/ready result hand-off.
module pulse_capture #(
    parameter int SIZE        = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            ena_i,
    input  logic            clear_i,
    input  logic            sig_i,
    input  logic [SIZE-1:0] prescale_i,
    input  logic [SIZE-1:0] timeout_i,
    output logic [SIZE-1:0] high_o,
    output logic [SIZE-1:0] period_o,
    output logic            valid_o,
    input  logic            ready_i,
    output logic            overrun_o,
    output logic            timeout_o,
    output logic            interrupt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [SIZE-1:0] ONE = {{(SIZE-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;
    logic [SIZE-1:0]        pre_q, pre_d;
    logic [SIZE-1:0]        cnt_q, cnt_d;
    logic [SIZE-1:0]        hold_q, hold_d;
    logic [SIZE-1:0]        high_q, high_d;
    logic [SIZE-1:0]        period_q, period_d;
    logic                   valid_q, valid_d;
    logic                   ovr_q, ovr_d;
    logic                   tmo_q, tmo_d;
    logic                   irq_q, irq_d;

    logic sync_s, rise, fall, tick, measuring, tmo_hit, publish;

    assign sync_s    = sync_q[SYNC_STAGES-1];
    assign rise      = sync_s & ~dly_q;
    assign fall      = ~sync_s & dly_q;
    assign tick      = (pre_q == prescale_i);
    assign measuring = (state_q != IDLE);
    assign tmo_hit   = measuring && (timeout_i != '0) && (cnt_q == timeout_i);

    // Input synchronizer plus one delay flop for edge detection
    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
            dly_q  <= sync_s;
        end
    end

    // Next-state: FSM, prescaler, counter, publish/handshake and flags
    always_comb begin
        state_d  = state_q;
        pre_d    = tick ? '0 : pre_q + ONE;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        high_d   = high_q;
        period_d = period_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;
        tmo_d    = tmo_q;
        irq_d    = 1'b0;
        publish  = 1'b0;

        if (valid_q && ready_i) valid_d = 1'b0;

        if (!ena_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            pre_d   = '0;
        end else begin
            if (rise) pre_d = '0;
            if (measuring && tick && !(&cnt_q)) cnt_d = cnt_q + ONE;
            unique case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d = HIGH;
                        cnt_d   = ONE;
                    end
                end
                HIGH: begin
                    if (tmo_hit) begin
                        state_d = IDLE;
                    end else if (fall) begin
                        hold_d  = cnt_q;
                        state_d = LOW;
                    end
                end
                LOW: begin
                    if (tmo_hit) begin
                        state_d = IDLE;
                    end else if (rise) begin
                        publish = 1'b1;
                        cnt_d   = ONE;
                        state_d = HIGH;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (tmo_hit) begin
                cnt_d = '0;
                tmo_d = 1'b1;
                irq_d = 1'b1;
            end
            if (publish) begin
                if (!valid_q || ready_i) begin
                    high_d   = hold_q;
                    period_d = cnt_q;
                    valid_d  = 1'b1;
                    irq_d    = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end
        end

        if (clear_i) begin
            state_d  = IDLE;
            cnt_d    = '0;
            high_d   = high_q;
            period_d = period_q;
            valid_d  = 1'b0;
            ovr_d    = 1'b0;
            tmo_d    = 1'b0;
            irq_d    = 1'b0;
        end
    end

    // State and result registers
    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            state_q  <= IDLE;
            pre_q    <= '0;
            cnt_q    <= '0;
            hold_q   <= '0;
            high_q   <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
            tmo_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            high_q   <= high_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
            tmo_q    <= tmo_d;
            irq_q    <= irq_d;
        end
    end

    assign high_o      = high_q;
    assign period_o    = period_q;
    assign valid_o     = valid_q;
    assign overrun_o   = ovr_q;
    assign timeout_o   = tmo_q;
    assign interrupt_o = irq_q;

endmodule

// File: tb/tb_pulse_capture.sv
// tb_pulse_capture: directed bench with a result scoreboard for pulse_capture
// (16-bit instance) plus an 8-bit instance for the saturation case.
module tb_pulse_capture;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        rst = 1'b1, ena = 1'b1, clr = 1'b0, rdy = 1'b1;
    logic        sig = 1'b0, sig8 = 1'b0;
    logic [15:0] pre = '0, tmo = '0;
    logic [7:0]  pre8 = '0, tmo8 = '0;

    logic [15:0] high, period;
    logic        valid, ovr, to, irq;
    logic [7:0]  high8, period8;
    logic        valid8, ovr8, to8, irq8;

    pulse_capture #(.SIZE(16), .SYNC_STAGES(2)) dut (
        .clk_i(clk_i), .rst_ni(rst), .ena_i(ena), .clear_i(clr),
        .sig_i(sig), .prescale_i(pre), .timeout_i(tmo),
        .high_o(high), .period_o(period), .valid_o(valid),
        .ready_i(rdy), .overrun_o(ovr), .timeout_o(to),
        .interrupt_o(irq)
    );

    pulse_capture #(.SIZE(8), .SYNC_STAGES(2)) dut8 (
        .clk_i(clk_i), .rst_ni(rst), .ena_i(ena), .clear_i(clr),
        .sig_i(sig8), .prescale_i(pre8), .timeout_i(tmo8),
        .high_o(high8), .period_o(period8), .valid_o(valid8),
        .ready_i(rdy), .overrun_o(ovr8), .timeout_o(to8),
        .interrupt_o(irq8)
    );

    typedef struct {
        logic [15:0] h;
        logic [15:0] p;
    } res_t;

    res_t q[$];
    res_t r_m;
    int   errors = 0, checks = 0, irq_cnt = 0;
    logic irq_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic pulse(input int h, input int l);
        sig = 1'b1;
        step(h);
        sig = 1'b0;
        step(l);
    endtask

    task automatic pulse8(input int h, input int l);
        sig8 = 1'b1;
        step(h);
        sig8 = 1'b0;
        step(l);
    endtask

    task automatic push(input logic [15:0] h, input logic [15:0] p);
        res_t r;
        r.h = h;
        r.p = p;
        q.push_back(r);
    endtask

    task automatic do_clear();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
    endtask

    // Scoreboard monitor: each new-result interrupt pops one expectation
    always @(negedge clk_i) begin
        if (irq) begin
            irq_cnt++;
            check("irq_width", {31'd0, irq_prev}, 32'd0);
            if (valid) begin
                if (q.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    r_m = q.pop_front();
                    check("sb_high", {16'd0, high}, {16'd0, r_m.h});
                    check("sb_period", {16'd0, period}, {16'd0, r_m.p});
                end
            end
        end
        irq_prev = irq;
    end

    initial begin
        int base;
        int n;

        step(3);
        check("rst_valid", {31'd0, valid}, 0);
        check("rst_high", {16'd0, high}, 0);
        check("rst_ovr", {31'd0, ovr}, 0);
        check("rst_irq", {31'd0, irq}, 0);
        rst = 1'b0;
        step(2);

        // T1: prescale 0, 10 high / 30 low
        push(10, 40);
        push(10, 40);
        base = irq_cnt;
        pulse(10, 30);
        check("t1_no_first", {31'd0, valid}, 0);
        pulse(10, 30);
        pulse(10, 30);
        step(5);
        check("t1_irq_count", irq_cnt - base, 2);
        check("t1_q_empty", q.size(), 0);
        do_clear();

        // T2: prescale 3, 40 high / 120 low
        pre = 16'd3;
        push(10, 40);
        pulse(40, 120);
        pulse(40, 120);
        step(5);
        check("t2_q_empty", q.size(), 0);
        do_clear();
        pre = 16'd0;

        // T3: consumer stalled, later results dropped
        rdy = 1'b0;
        push(10, 40);
        pulse(10, 30);
        pulse(12, 28);
        pulse(10, 30);
        pulse(10, 30);
        step(2);
        check("t3_high", {16'd0, high}, 10);
        check("t3_period", {16'd0, period}, 40);
        check("t3_valid", {31'd0, valid}, 1);
        check("t3_ovr", {31'd0, ovr}, 1);
        rdy = 1'b1;
        step(1);
        rdy = 1'b0;
        check("t3_valid_drop", {31'd0, valid}, 0);
        check("t3_ovr_held", {31'd0, ovr}, 1);
        step(3);
        check("t3_ovr_sticky", {31'd0, ovr}, 1);
        check("t3_high_kept", {16'd0, high}, 10);
        do_clear();
        check("t3_ovr_clr", {31'd0, ovr}, 0);
        rdy = 1'b1;

        // T4: timeout at 100 ticks
        tmo = 16'd100;
        sig = 1'b1;
        n = 0;
        while (!to && n < 200) begin
            step(1);
            n++;
        end
        check("t4_latency", n, 103);
        check("t4_irq", {31'd0, irq}, 1);
        check("t4_no_valid", {31'd0, valid}, 0);
        step(1);
        check("t4_irq_end", {31'd0, irq}, 0);
        check("t4_to_sticky", {31'd0, to}, 1);
        step(20);
        sig = 1'b0;
        step(30);
        push(10, 40);
        pulse(10, 30);
        check("t4_no_first", {31'd0, valid}, 0);
        check("t4_q_pending", q.size(), 1);
        pulse(10, 30);
        step(3);
        check("t4_q_empty", q.size(), 0);
        tmo = 16'd0;
        do_clear();
        check("t4_to_clr", {31'd0, to}, 0);

        // T5: 8-bit instance saturates the period
        pulse8(20, 280);
        pulse8(20, 280);
        step(5);
        check("t5_high8", {24'd0, high8}, 20);
        check("t5_period8", {24'd0, period8}, 255);
        do_clear();

        // T6: asynchronous reset mid-measurement
        rdy = 1'b0;
        push(10, 40);
        pulse(10, 30);
        pulse(10, 30);
        pulse(10, 30);
        sig = 1'b1;
        step(6);
        check("t6_pre_valid", {31'd0, valid}, 1);
        check("t6_pre_ovr", {31'd0, ovr}, 1);
        #3;
        rst = 1'b1;
        sig = 1'b0;
        #1;
        check("t6_high", {16'd0, high}, 0);
        check("t6_period", {16'd0, period}, 0);
        check("t6_valid", {31'd0, valid}, 0);
        check("t6_ovr", {31'd0, ovr}, 0);
        check("t6_to", {31'd0, to}, 0);
        check("t6_irq", {31'd0, irq}, 0);
        check("t6_high8", {24'd0, high8}, 0);
        step(2);
        rst = 1'b0;
        rdy = 1'b1;
        step(3);
        pulse(10, 30);
        check("t6_no_first", {31'd0, valid}, 0);
        push(10, 40);
        pulse(10, 30);
        step(3);
        check("t6_q_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pulse_capture.md
Name: pulse_capture

Overview:
- Input-capture counterpart to the SoC up-counter timer: measures, instead of generates, timed events.
- Measures high time and period of an external pulse train (RC receiver PWM, ESC telemetry) in prescaled clock ticks.
- Results go to the register/bus side through a valid/ready handshake, plus a single interrupt line.
- Sits between a pad input and a peripheral register block.

Parameters:
SIZE, 16, width of counters, results, prescale and timeout values
SYNC_STAGES, 2, flip-flop stages in the input synchronizer (>=2)

Ports:
clk_i  input  1  system clock
rst_ni  input  1  reset, asynchronous, active-high (asserted = 1)
ena_i  input  1  capture enable
clear_i  input  1  synchronous clear of FSM, valid_o and sticky flags
sig_i  input  1  asynchronous pulse input
prescale_i  input  SIZE  tick every prescale_i+1 clocks (0 = every clock)
timeout_i  input  SIZE  max ticks in a measuring state; 0 disables timeout
high_o  output  SIZE  captured high time in ticks
period_o  output  SIZE  captured rising-to-rising period in ticks
valid_o  output  1  result pair valid
ready_i  input  1  consumer accepts result
overrun_o  output  1  sticky: a completed measurement was dropped
timeout_o  output  1  sticky: timeout occurred
interrupt_o  output  1  one-cycle pulse on new result or timeout

Behaviour:
- Reset: one clock, asynchronous active-high reset on rst_ni. All outputs, counters, synchronizer and FSM go to 0/IDLE immediately on assertion, including mid-measurement.
- Input path and edge detect:
  - sig_i passes through SYNC_STAGES flops, then one delay flop.
  - Rise = sync 1 and delayed 0; fall = sync 0 and delayed 1.
  - Edge detection latency is SYNC_STAGES+1 clocks from sig_i.
- Prescaler:
  - Counts 0..prescale_i; a tick occurs on the cycle it equals prescale_i, then it wraps to 0.
  - Forced to 0 on every detected rise.
- Counter:
  - On a rise, count loads 1.
  - Otherwise count increments on each tick in HIGH/LOW, saturating at all-ones (no wrap).
  - Latches always use the current register value, before any same-cycle increment.
- FSM states:
  - IDLE: wait for rise. On rise -> HIGH, load counter. No result is produced, so the first result needs two rises.
  - HIGH: on fall, high_hold <= count, -> LOW.
  - LOW: on rise, publish period = count and high = high_hold, reload counter, stay in measurement with -> HIGH.
  - Timeout: in HIGH or LOW, if timeout_i != 0 and count == timeout_i, -> IDLE, set timeout_o, pulse interrupt_o. Timeout has priority over an edge in the same cycle.
- Publish and handshake:
  - If valid_o = 0, or valid_o = 1 with ready_i = 1 in the same cycle: high_o/period_o update, valid_o = 1 on the next cycle, interrupt_o pulses that same next cycle.
  - If valid_o = 1 and ready_i = 0: new result dropped, held outputs unchanged, overrun_o set.
  - valid_o && ready_i with no publish: valid_o clears next cycle; high_o/period_o keep their last values.
- ena_i = 0:
  - FSM forced to IDLE; counter and prescaler held at 0.
  - Synchronizer keeps running; outputs and handshake still operate.
  - Re-enable requires a fresh rise.
- clear_i:
  - Next cycle: FSM IDLE, valid_o = 0, overrun_o = 0, timeout_o = 0, no interrupt.
  - high_o/period_o retain their values.
  - clear_i overrides a same-cycle publish or timeout.
- Changing prescale_i or timeout_i mid-measurement is allowed. The result is undefined for that measurement only; recovery happens at the next rise.

Test Plan:
1. prescale_i=0, timeout_i=0, sig_i high 10 / low 30 clocks, repeated, ready_i=1 -> first valid_o after second rise, high_o=10, period_o=40, interrupt_o exactly 1 cycle per result.
2. prescale_i=3, sig_i high 40 / low 120 clocks -> high_o=10, period_o=40.
3. ready_i=0, three periods of scenario 1 with the second period high 12 -> first result (10/40) held, overrun_o=1; raise ready_i one cycle -> valid_o drops next cycle, overrun_o stays 1 until clear_i.
4. timeout_i=100, prescale_i=0, sig_i rises then stays high -> timeout_o=1 and interrupt_o pulse when count reaches 100, FSM IDLE, no valid_o; toggling resumes -> valid_o only after two further rises.
5. SIZE=8, timeout_i=0, high 20 / low 280 clocks -> high_o=20, period_o=255 (saturated).
6. rst_ni asserted asynchronously (between clock edges) during HIGH with valid_o=1 and overrun_o=1 -> all outputs 0 before next clock edge; after release, first rise produces no result.
